b16_uart: RTL

//  Memory-mapped 8N1 UART slave on the b16 cpu data bus (downstream of cpu addr/rd/wr/dataout).

---
 rtl/b16_uart_pkg.sv | 41 ++++
 rtl/b16_uart_if.sv | 18 +
 rtl/b16_fifo.sv | 64 ++++++
 rtl/b16_uart.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/b16_uart_pkg.sv
// b16_uart_pkg: shared definitions for the b16 memory-mapped UART.
//   - register indices (addr[3:1]) within the 16-byte I/O page
//   - STAT bit positions
//   - TX / RX state encodings
//   - half_bit_load(): counter preload giving a (div+1)/2 clock delay
package b16_uart_pkg;

  localparam logic [2:0] REG_DATA = 3'd0;
  localparam logic [2:0] REG_STAT = 3'd1;
  localparam logic [2:0] REG_DIV  = 3'd2;

  localparam int STAT_RXAV   = 0;
  localparam int STAT_TXNF   = 1;
  localparam int STAT_OVR    = 2;
  localparam int STAT_TXIDLE = 3;
  localparam int STAT_FERR   = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // A down-counter loaded with N expires N+1 clocks later, so the start-bit
  // resample point (div+1)/2 clocks after the edge needs a preload of
  // (div+1)/2 - 1. div=0 would underflow; clamp to 0.
  function automatic logic [15:0] half_bit_load(input logic [15:0] div);
    logic [16:0] half;
    half = ({1'b0, div} + 17'd1) >> 1;
    return (half == 17'd0) ? 16'd0 : 16'(half - 17'd1);
  endfunction

endpackage

// File: rtl/b16_uart_if.sv
// b16_uart_if: b16 cpu data-bus slice seen by an I/O slave.
//   addr  cpu byte address
//   rd    read strobe
//   wr    write lanes, wr[1] = din[15:8], wr[0] = din[7:0]
//   din   cpu dataout
//   dout  slave read data (0 when not addressed, so slaves can be ORed)
interface b16_uart_if #(
  parameter int l = 16
);
  logic [l-1:0] addr;
  logic         rd;
  logic [1:0]   wr;
  logic [l-1:0] din;
  logic [l-1:0] dout;

  modport master (output addr, rd, wr, din, input dout);
  modport slave  (input addr, rd, wr, din, output dout);
endinterface

// File: rtl/b16_fifo.sv
// b16_fifo: small synchronous byte FIFO, 2^fdep entries.
//   clk, nreset  clock, synchronous active-low reset (empties the FIFO)
//   push, din    write request / data; dropped when full unless popping
//   pop          read request; ignored when empty
//   dout         head entry (combinational, stale when empty)
//   full, empty  status
// Push and pop in the same cycle both take effect, even when full.
module b16_fifo #(
  parameter int fdep = 2,
  parameter int w    = 8
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         push,
  input  logic         pop,
  input  logic [w-1:0] din,
  output logic [w-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int depth = 1 << fdep;

  logic [w-1:0]    mem [depth];
  logic [fdep-1:0] wptr_reg;
  logic [fdep-1:0] rptr_reg;
  logic [fdep:0]   count_reg;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (fdep+1)'(depth));
  assign do_pop  = pop && !empty;
  // A pop frees the slot this same edge, so a push into a full FIFO is kept.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) begin
        wptr_reg <= wptr_reg + 1'b1;
      end
      if (do_pop) begin
        rptr_reg <= rptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/b16_uart.sv
// b16_uart: memory-mapped 8N1 UART slave on the b16 cpu data bus.
//   clk     clock
//   nreset  synchronous, active-low reset
//   bus     cpu bus slice (addr/rd/wr/din in, dout out)
//   txd     serial out, idle high
//   rxd     serial in, asynchronous to clk
// Page select: addr[l-1:4] == iobase. Registers at addr[3:1]:
//   0 DATA  write: push TX byte; read: {rxb,rxb} and pop RX (0 if empty)
//   1 STAT  {ferr, txidle, ovr, txnf, rxav}; write bit2 clears ovr, bit4 ferr
//   2 DIV   bit time = div+1 clocks, byte-lane writable
// Read data is combinational so a cpu load completes in the same cycle.
module b16_uart
  import b16_uart_pkg::*;
#(
  parameter int          l      = 16,
  parameter logic [11:0] iobase = 12'hFFD,
  parameter int          fdep   = 2,
  parameter logic [15:0] div0   = 16'd433
) (
  input  logic        clk,
  input  logic        nreset,
  b16_uart_if.slave   bus,
  output logic        txd,
  input  logic        rxd
);

  // ---------------------------------------------------------------- decode
  logic       sel;
  logic [2:0] idx;
  logic       wr_any;
  logic       stat_wr;
  logic       div_wr;
  logic       unused_addr0;

  assign sel          = (bus.addr[l-1:4] == iobase);
  assign idx          = bus.addr[3:1];
  assign wr_any       = |bus.wr;
  assign stat_wr      = sel && wr_any && (idx == REG_STAT);
  assign div_wr       = sel && wr_any && (idx == REG_DIV);
  assign unused_addr0 = bus.addr[0];

  // ----------------------------------------------------------------- FIFOs
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_byte, tx_fifo_dout;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_fifo_dout;

  assign tx_push = sel && wr_any && (idx == REG_DATA);
  assign tx_byte = bus.wr[0] ? bus.din[7:0] : bus.din[15:8];
  assign rx_pop  = sel && bus.rd && (idx == REG_DATA) && !rx_empty;

  b16_fifo #(.fdep(fdep), .w(8)) u_tx_fifo (
    .clk    (clk),
    .nreset (nreset),
    .push   (tx_push),
    .pop    (tx_pop),
    .din    (tx_byte),
    .dout   (tx_fifo_dout),
    .full   (tx_full),
    .empty  (tx_empty)
  );

  logic [7:0] rx_sh_reg;

  b16_fifo #(.fdep(fdep), .w(8)) u_rx_fifo (
    .clk    (clk),
    .nreset (nreset),
    .push   (rx_push),
    .pop    (rx_pop),
    .din    (rx_sh_reg),
    .dout   (rx_fifo_dout),
    .full   (rx_full),
    .empty  (rx_empty)
  );

  // ------------------------------------------------- divisor and flag regs
  logic [15:0] div_reg;
  logic        ovr_reg;
  logic        ferr_reg;
  logic        ovr_set;
  logic        ferr_set;

  // A pop in the same cycle makes room, so that is not an overrun.
  assign ovr_set = rx_push && rx_full && !rx_pop;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      div_reg  <= div0;
      ovr_reg  <= 1'b0;
      ferr_reg <= 1'b0;
    end else begin
      if (div_wr && bus.wr[1]) begin
        div_reg[15:8] <= bus.din[15:8];
      end
      if (div_wr && bus.wr[0]) begin
        div_reg[7:0] <= bus.din[7:0];
      end
      // A new error in the clearing cycle wins so no event is lost.
      if (ovr_set) begin
        ovr_reg <= 1'b1;
      end else if (stat_wr && bus.din[STAT_OVR]) begin
        ovr_reg <= 1'b0;
      end
      if (ferr_set) begin
        ferr_reg <= 1'b1;
      end else if (stat_wr && bus.din[STAT_FERR]) begin
        ferr_reg <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- TX FSM
  // Counters count down from div; reloading div at each bit boundary is what
  // makes a divisor write take effect on the next bit.
  tx_state_t   tx_state_reg, tx_state_next;
  logic [15:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0]  tx_bit_reg, tx_bit_next;
  logic [7:0]  tx_sh_reg, tx_sh_next;
  logic        txd_reg, txd_next;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_sh_reg    <= '0;
      txd_reg      <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_sh_reg    <= tx_sh_next;
      txd_reg      <= txd_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_bit_next   = tx_bit_reg;
    tx_sh_next    = tx_sh_reg;
    tx_pop        = 1'b0;
    case (tx_state_reg)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop        = 1'b1;
          tx_state_next = TX_START;
          tx_cnt_next   = div_reg;
          tx_sh_next    = tx_fifo_dout;
        end
      end
      TX_START: begin
        if (tx_cnt_reg == '0) begin
          tx_state_next = TX_DATA;
          tx_cnt_next   = div_reg;
          tx_bit_next   = 3'd0;
        end else begin
          tx_cnt_next = tx_cnt_reg - 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_reg == '0) begin
          tx_cnt_next = div_reg;
          tx_sh_next  = tx_sh_reg >> 1;
          if (tx_bit_reg == 3'd7) begin
            tx_state_next = TX_STOP;
          end else begin
            tx_bit_next = tx_bit_reg + 1'b1;
          end
        end else begin
          tx_cnt_next = tx_cnt_reg - 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_reg == '0) begin
          // Chain straight into the next start bit: no idle gap.
          if (!tx_empty) begin
            tx_pop        = 1'b1;
            tx_state_next = TX_START;
            tx_cnt_next   = div_reg;
            tx_sh_next    = tx_fifo_dout;
          end else begin
            tx_state_next = TX_IDLE;
          end
        end else begin
          tx_cnt_next = tx_cnt_reg - 1'b1;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase

    // txd is registered from the next state so it changes on the same edge
    // as the state register.
    case (tx_state_next)
      TX_START: txd_next = 1'b0;
      TX_DATA:  txd_next = tx_sh_next[0];
      default:  txd_next = 1'b1;
    endcase
  end

  assign txd = txd_reg;

  // ---------------------------------------------------------------- RX FSM
  logic        rx_s1_reg, rx_s2_reg, rx_prev_reg;
  rx_state_t   rx_state_reg, rx_state_next;
  logic [15:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0]  rx_bit_reg, rx_bit_next;
  logic [7:0]  rx_sh_next;

  // Two-flop synchronizer plus one more stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      rx_s1_reg   <= 1'b1;
      rx_s2_reg   <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_s1_reg   <= rxd;
      rx_s2_reg   <= rx_s1_reg;
      rx_prev_reg <= rx_s2_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_sh_reg    <= '0;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_sh_reg    <= rx_sh_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg;
    rx_bit_next   = rx_bit_reg;
    rx_sh_next    = rx_sh_reg;
    rx_push       = 1'b0;
    ferr_set      = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        if (rx_prev_reg && !rx_s2_reg) begin
          rx_state_next = RX_START;
          rx_cnt_next   = half_bit_load(div_reg);
        end
      end
      RX_START: begin
        if (rx_cnt_reg == '0) begin
          if (rx_s2_reg) begin
            // Line back high at mid start bit: treat as a glitch.
            rx_state_next = RX_IDLE;
          end else begin
            rx_state_next = RX_DATA;
            rx_cnt_next   = div_reg;
            rx_bit_next   = 3'd0;
          end
        end else begin
          rx_cnt_next = rx_cnt_reg - 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_reg == '0) begin
          rx_sh_next  = {rx_s2_reg, rx_sh_reg[7:1]};
          rx_cnt_next = div_reg;
          if (rx_bit_reg == 3'd7) begin
            rx_state_next = RX_STOP;
          end else begin
            rx_bit_next = rx_bit_reg + 1'b1;
          end
        end else begin
          rx_cnt_next = rx_cnt_reg - 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_reg == '0) begin
          rx_state_next = RX_IDLE;
          if (rx_s2_reg) begin
            rx_push = 1'b1;
          end else begin
            ferr_set = 1'b1;
          end
        end else begin
          rx_cnt_next = rx_cnt_reg - 1'b1;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  // ------------------------------------------------------------- read mux
  logic         txidle;
  logic [l-1:0] rd_data;

  assign txidle = tx_empty && (tx_state_reg == TX_IDLE);

  always_comb begin
    rd_data = '0;
    if (sel && bus.rd) begin
      case (idx)
        REG_DATA: begin
          if (!rx_empty) begin
            rd_data[15:0] = {rx_fifo_dout, rx_fifo_dout};
          end
        end
        REG_STAT: begin
          rd_data[STAT_RXAV]   = !rx_empty;
          rd_data[STAT_TXNF]   = !tx_full;
          rd_data[STAT_OVR]    = ovr_reg;
          rd_data[STAT_TXIDLE] = txidle;
          rd_data[STAT_FERR]   = ferr_reg;
        end
        REG_DIV: begin
          rd_data[15:0] = div_reg;
        end
        default: rd_data = '0;
      endcase
    end
  end

  assign bus.dout = rd_data;

endmodule
